// File: rtl/serializer_pkg.sv
// Shared definitions for the 16-bit serializer and its matching deserializer.
package serializer_pkg;

    localparam int DATA_W = 16;
    localparam int MOD_W  = $clog2(DATA_W);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [MOD_W-1:0]  mod_t;
    typedef logic [MOD_W:0]    cnt_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // A full word is reported as 0 so the count fits the serializer's mod field.
    function automatic mod_t count_to_mod(input cnt_t count);
        return (count == cnt_t'(DATA_W)) ? '0 : count[MOD_W-1:0];
    endfunction

endpackage

// File: rtl/top_deserializer.sv
// Reassembles MSB-first valid bursts into left-aligned words with a bit count
// in the serializer's mod encoding; long bursts split into full words plus a tail.
module top_deserializer
    import serializer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              i_srst_n,
    input  logic              i_data,
    input  logic              i_data_val,
    output logic [DATA_W-1:0] o_data,
    output logic [MOD_W-1:0]  o_data_mod,
    output logic              o_data_val,
    output logic              o_busy
);

    localparam int CW = MOD_W + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DATA_W);
    localparam logic [MOD_W-1:0] TOP_IDX  = MOD_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [MOD_W-1:0]  mod_q,   mod_d;
    logic              val_q,   val_d;
    logic              busy_q,  busy_d;

    logic [MOD_W-1:0]  wr_idx;
    logic [DATA_W-1:0] acc_wr;
    logic [CW-1:0]     count_inc;

    always_ff @(posedge clk) begin
        if (!i_srst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    // Accumulator with the incoming bit written at DATA_W-1-count.
    always_comb begin
        wr_idx          = TOP_IDX - count_q[MOD_W-1:0];
        acc_wr          = acc_q;
        acc_wr[wr_idx]  = i_data;
        count_inc       = count_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_data_val) begin
                    acc_d           = '0;
                    acc_d[TOP_IDX]  = i_data;
                    count_d         = CW'(1);
                    state_d         = COLLECT;
                end
            end
            COLLECT: begin
                if (i_data_val) begin
                    if (count_inc == FULL_CNT) begin
                        // Word complete: emit and restart so the next bit opens a new word.
                        data_d  = acc_wr;
                        mod_d   = '0;
                        val_d   = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d   = acc_wr;
                        count_d = count_inc;
                    end
                end else begin
                    // Burst ended early: flush the partial word with its bit count.
                    data_d  = acc_q;
                    mod_d   = count_q[MOD_W-1:0];
                    val_d   = 1'b1;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (count_d != '0);
    end

    assign o_data     = data_q;
    assign o_data_mod = mod_q;
    assign o_data_val = val_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_top_deserializer.sv
// Directed bench for top_deserializer: table of single bursts plus hand-written
// multi-cycle sequences (long burst, back-to-back, exact two words, reset mid-word).
module tb_top_deserializer;

    logic        clk = 1'b0;
    logic        i_srst_n;
    logic        i_data;
    logic        i_data_val;
    logic [15:0] o_data;
    logic [3:0]  o_data_mod;
    logic        o_data_val;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [19:0] exp_q[$];
    int          pulse_cyc_q[$];

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic [15:0] exp_data;
        logic [3:0]  exp_mod;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    top_deserializer dut (
        .clk        (clk),
        .i_srst_n   (i_srst_n),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_data     (o_data),
        .o_data_mod (o_data_mod),
        .o_data_val (o_data_val),
        .o_busy     (o_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse is matched against the expected queue.
    always @(negedge clk) begin
        if (o_data_val) begin
            pulse_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got data 0x%0h mod %0d expected no pulse",
                         o_data, o_data_mod);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({o_data, o_data_mod} != e) begin
                    n_errors++;
                    $display("FAIL pulse_word: got data 0x%0h mod %0d expected data 0x%0h mod %0d",
                             o_data, o_data_mod, e[19:4], e[3:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic b, input logic v);
        i_data     = b;
        i_data_val = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int len);
        for (int i = 0; i < len; i++) drive(w[15-i], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [3:0] m);
        exp_q.push_back({d, m});
    endtask

    task automatic check_pulses(input string name, input int start, input int n,
                                input int lat0, input int lat1);
        check({name, "_pulse_count"}, pulse_cyc_q.size(), n);
        if (pulse_cyc_q.size() >= 1 && n >= 1)
            check({name, "_latency0"}, pulse_cyc_q[0] - start, lat0);
        if (pulse_cyc_q.size() >= 2 && n >= 2)
            check({name, "_latency1"}, pulse_cyc_q[1] - start, lat1);
        check({name, "_missing_words"}, exp_q.size(), 0);
        check({name, "_busy_after"}, int'(o_busy), 0);
        exp_q.delete();
        pulse_cyc_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int start;

        // Latency counted from the cycle carrying the first bit (that cycle = 0).
        vecs[0] = '{16'hA5C3, 16, 16'hA5C3, 4'd0,  16};
        vecs[1] = '{16'hC800,  5, 16'hC800, 4'd5,   6};
        vecs[2] = '{16'hA000,  3, 16'hA000, 4'd3,   4};
        vecs[3] = '{16'h7000,  4, 16'h7000, 4'd4,   5};
        vecs[4] = '{16'h8000,  1, 16'h8000, 4'd1,   2};
        vecs[5] = '{16'h4000,  2, 16'h4000, 4'd2,   3};
        vecs[6] = '{16'hFFFE, 15, 16'hFFFE, 4'd15, 16};
        vecs[7] = '{16'h1234, 16, 16'h1234, 4'd0,  16};

        i_srst_n   = 1'b0;
        i_data     = 1'b1;
        i_data_val = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_data", int'(o_data), 0);
        check("reset_mod",  int'(o_data_mod), 0);
        check("reset_val",  int'(o_data_val), 0);
        check("reset_busy", int'(o_busy), 0);
        i_srst_n = 1'b1;
        idle(2);
        pulse_cyc_q.delete();

        for (int v = 0; v < 8; v++) begin
            expect_word(vecs[v].exp_data, vecs[v].exp_mod);
            start = cyc;
            send_bits(vecs[v].bits, vecs[v].len);
            idle(4);
            check_pulses($sformatf("vec%0d", v), start, 1, vecs[v].exp_lat, 0);
            check($sformatf("vec%0d_hold_data", v), int'(o_data), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_hold_mod", v),  int'(o_data_mod), int'(vecs[v].exp_mod));
        end

        // Long burst: full word then a 4-bit tail, no bit lost at the boundary.
        expect_word(16'hFFFF, 4'd0);
        expect_word(16'hA000, 4'd4);
        start = cyc;
        send_bits(16'hFFFF, 16);
        check("long_busy_at_boundary", int'(o_busy), 0);
        send_bits(16'hA000, 4);
        idle(4);
        check_pulses("long", start, 2, 16, 21);

        // Back-to-back bursts separated by a single idle cycle.
        expect_word(16'hA000, 4'd3);
        expect_word(16'h7000, 4'd4);
        start = cyc;
        send_bits(16'hA000, 3);
        idle(1);
        send_bits(16'h7000, 4);
        idle(4);
        check_pulses("b2b", start, 2, 4, 9);

        // Exactly two words: no zero-length flush afterwards.
        expect_word(16'hDEAD, 4'd0);
        expect_word(16'hBEEF, 4'd0);
        start = cyc;
        send_bits(16'hDEAD, 16);
        send_bits(16'hBEEF, 16);
        idle(4);
        check_pulses("two_words", start, 2, 16, 32);

        // Reset mid-word discards the partial word without a flush.
        send_bits(16'hFF80, 9);
        check("mid_busy", int'(o_busy), 1);
        i_srst_n = 1'b0;
        drive(1'b0, 1'b0);
        i_srst_n = 1'b1;
        check("midrst_data", int'(o_data), 0);
        check("midrst_mod",  int'(o_data_mod), 0);
        check("midrst_val",  int'(o_data_val), 0);
        check("midrst_busy", int'(o_busy), 0);
        idle(3);
        check("midrst_no_pulse", pulse_cyc_q.size(), 0);
        expect_word(16'h1234, 4'd0);
        start = cyc;
        send_bits(16'h1234, 16);
        idle(4);
        check_pulses("after_rst", start, 1, 16, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
